// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: state encodings exposed on debug, frame geometry,
// default timing, and the frame builder used when a byte is accepted.
package ps2_pkg;

  localparam int PS2_FRAME_BITS      = 11;
  localparam int PS2_HALF_PERIOD_DEF = 2000;
  localparam int PS2_IDLE_HOLD_DEF   = 2500;

  // First cycle of the high phase at which a low clock counts as host inhibit;
  // earlier cycles may still see our own low clock through the synchronizer.
  localparam int PS2_INHIBIT_START = 4;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_WAIT_BUS = 4'd1;
  localparam logic [3:0] ST_BIT_HIGH = 4'd2;
  localparam logic [3:0] ST_BIT_LOW  = 4'd3;
  localparam logic [3:0] ST_GAP      = 4'd4;

  // {stop, odd parity, data[7:0], start}; bit 0 goes on the wire first.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line; resets to the idle (high) level.
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: drives the PS/2 clock and shifts one byte out
// as an 11-bit frame, aborting if the host inhibits during a bit high phase.
module ps2_device_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = PS2_HALF_PERIOD_DEF,
  parameter int IDLE_HOLD   = PS2_IDLE_HOLD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_aborted,
  inout  logic       ps2_clk,
  inout  logic       ps2_data,
  output logic [3:0] debug
);

  // Handshake: tx_start is a single-cycle request honoured only in IDLE;
  // tx_busy covers the whole transfer and drops in the cycle tx_done or
  // tx_aborted pulses, so every accepted byte ends in exactly one of them.

  localparam int CNT_MAX = (HALF_PERIOD > IDLE_HOLD) ? HALF_PERIOD : IDLE_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(IDLE_HOLD - 1);
  localparam logic [CNT_W-1:0] INH_FIRST = CNT_W'(PS2_INHIBIT_START);
  localparam logic [3:0]       LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  logic [3:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [3:0]                bit_idx;
  logic [PS2_FRAME_BITS-1:0] frame;

  logic clk_s;
  logic data_s;
  logic clk_low;
  logic data_low;
  logic half_end;
  logic inhibit;

  ps2_sync u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .d     (ps2_clk),
    .q     (clk_s)
  );

  ps2_sync u_sync_data (
    .clk   (clk),
    .reset (reset),
    .d     (ps2_data),
    .q     (data_s)
  );

  assign half_end = (cnt == HALF_LAST);
  assign inhibit  = (state == ST_BIT_HIGH) && !clk_s && (cnt >= INH_FIRST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      tx_done    <= 1'b0;
      tx_aborted <= 1'b0;
    end else begin
      tx_done    <= 1'b0;
      tx_aborted <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            frame   <= ps2_frame(tx_data);
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_WAIT_BUS;
          end
        end
        ST_WAIT_BUS: begin
          if (!(clk_s && data_s)) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_BIT_HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BIT_HIGH: begin
          if (inhibit) begin
            cnt        <= '0;
            bit_idx    <= '0;
            tx_aborted <= 1'b1;
            state      <= ST_IDLE;
          end else if (half_end) begin
            cnt   <= '0;
            state <= ST_BIT_LOW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_BIT_LOW: begin
          if (half_end) begin
            cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              state <= ST_GAP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              frame   <= {1'b1, frame[PS2_FRAME_BITS-1:1]};
              state   <= ST_BIT_HIGH;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (half_end) begin
            cnt     <= '0;
            tx_done <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive enables decode straight from state so an async reset frees the bus at once.
  always_comb begin
    clk_low  = 1'b0;
    data_low = 1'b0;
    if (state == ST_BIT_HIGH || state == ST_BIT_LOW) begin
      data_low = !frame[0];
    end
    if (state == ST_BIT_LOW) begin
      clk_low = 1'b1;
    end
  end

  assign ps2_clk  = clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = data_low ? 1'b0 : 1'bz;

  assign tx_busy = (state != ST_IDLE);
  assign debug   = state;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: pulled-up open-drain bus with a host model
// that samples data on clock falling edges and can inhibit the clock.
module tb_ps2_device_tx;
  import ps2_pkg::*;

  localparam int HP = 8;
  localparam int IH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_aborted;
  logic [3:0] debug;
  wire        ps2_clk;
  wire        ps2_data;

  logic host_clk_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;

  ps2_device_tx #(
    .HALF_PERIOD (HP),
    .IDLE_HOLD   (IH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_aborted (tx_aborted),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .debug      (debug)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard of frames the host should see, value bit i = i-th bit on the wire
  logic [10:0] exp_q[$];

  // host model
  logic [10:0] rx_sh = '0;
  int          rx_cnt = 0;
  int          clr_req = 0;
  int          clr_ack = 0;

  always @(negedge ps2_clk) begin
    if (clr_req != clr_ack) begin
      rx_cnt  = 0;
      clr_ack = clr_req;
    end
    if (!host_clk_low) begin
      rx_sh = {ps2_data === 1'b1, rx_sh[10:1]};
      rx_cnt++;
      if (rx_cnt == 11) begin
        rx_cnt = 0;
        if (exp_q.size() == 0) check("host_frame_unexpected", 32'(rx_sh), 32'h0);
        else check("host_frame", 32'(rx_sh), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic int frame_bits();
    return (clr_req != clr_ack) ? 0 : rx_cnt;
  endfunction

  task automatic host_clear();
    clr_req++;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [10:0] frame, input string tag,
                            input int poke_at, input bit gap_pull);
    int lat;
    int gap_cnt;
    bit busy_held;
    bit abort_seen;
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    exp_q.push_back(frame);
    @(negedge clk);
    tx_start = 1'b0;
    check({tag, "_busy_rise"}, 32'(tx_busy), 32'd1);
    lat = 0; gap_cnt = 0; busy_held = 1'b1; abort_seen = 1'b0;
    while (!tx_done && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (lat == poke_at) begin
        tx_data  = 8'hFF;
        tx_start = 1'b1;
      end
      if (lat == poke_at + 1) tx_start = 1'b0;
      if (gap_pull && gap_cnt == 0 && debug == ST_GAP) begin
        host_clk_low = 1'b1;
        gap_cnt = 1;
      end else if (gap_cnt > 0 && gap_cnt < 4) begin
        gap_cnt++;
        if (gap_cnt == 4) host_clk_low = 1'b0;
      end
      if (tx_aborted) abort_seen = 1'b1;
      if (!tx_done && !tx_busy) busy_held = 1'b0;
    end
    check({tag, "_latency"}, 32'(lat), 32'(IH + 23 * HP));
    check({tag, "_busy_held"}, 32'(busy_held), 32'd1);
    check({tag, "_busy_fall"}, 32'(tx_busy), 32'd0);
    check({tag, "_no_abort"}, 32'(abort_seen), 32'd0);
    check({tag, "_lines_free"}, 32'({ps2_clk, ps2_data}), 32'h3);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(tx_done), 32'd0);
    check({tag, "_frame_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic abort_test(input logic [7:0] b, input int bit_i, input logic lvl, input string tag);
    int guard;
    bit quiet;
    host_clear();
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    guard = 0;
    while (!(frame_bits() == bit_i && debug == ST_BIT_HIGH) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_reach_bit"}, 32'(guard < 1000), 32'd1);
    @(negedge clk);
    check({tag, "_data_drive"}, 32'(ps2_data), 32'(lvl));
    host_clk_low = 1'b1;
    guard = 0;
    while (!tx_aborted && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    // two synchronizer cycles, wait for window cycle 4, then one register stage
    check({tag, "_abort_latency"}, 32'(guard), 32'd4);
    check({tag, "_debug_idle"}, 32'(debug), 32'(ST_IDLE));
    check({tag, "_busy_low"}, 32'(tx_busy), 32'd0);
    check({tag, "_no_done"}, 32'(tx_done), 32'd0);
    check({tag, "_data_free"}, 32'(ps2_data), 32'd1);
    @(negedge clk);
    check({tag, "_abort_pulse"}, 32'(tx_aborted), 32'd0);
    repeat (5) @(negedge clk);
    host_clk_low = 1'b0;
    quiet = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (tx_done || tx_aborted || tx_busy) quiet = 1'b0;
    end
    check({tag, "_stays_idle"}, 32'(quiet), 32'd1);
    host_clear();
  endtask

  initial begin
    int lat;
    int guard;
    bit ok;
    reset    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_aborted", 32'(tx_aborted), 32'd0);
    check("rst_debug", 32'(debug), 32'(ST_IDLE));
    check("rst_lines", 32'({ps2_clk, ps2_data}), 32'h3);
    reset = 1'b1;
    @(negedge clk);
    host_clear();

    // basic frames, back to back
    send_frame(8'h1C, 11'h438, "send_1c", -1, 1'b0);
    send_frame(8'h00, 11'h600, "send_00", -1, 1'b0);
    send_frame(8'hFF, 11'h7FE, "send_ff", -1, 1'b0);

    // inhibit in bit 5 high phase and in stop-bit high phase
    abort_test(8'hA5, 5, 1'b0, "abort_bit5");
    abort_test(8'hA5, 10, 1'b1, "abort_stop");

    // inhibit during GAP is ignored
    send_frame(8'hA5, 11'h74A, "gap_inhibit", -1, 1'b1);

    // host holds clock low when the request arrives
    host_clear();
    host_clk_low = 1'b1;
    repeat (3) @(negedge clk);
    tx_data  = 8'h3C;
    tx_start = 1'b1;
    exp_q.push_back(11'h678);
    @(negedge clk);
    tx_start = 1'b0;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (debug != ST_WAIT_BUS || ps2_data !== 1'b1) ok = 1'b0;
    end
    check("inh_wait_bus", 32'(ok), 32'd1);
    host_clk_low = 1'b0;
    lat = 0;
    while (ps2_data !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    // IDLE_HOLD plus the two synchronizer cycles before the release is seen
    check("inh_release_to_drive", 32'(lat), 32'(IH + 2));
    lat = 0;
    while (!tx_done && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    check("inh_drive_to_done", 32'(lat), 32'(23 * HP));
    @(negedge clk);
    check("inh_frame_seen", 32'(exp_q.size()), 32'd0);

    // tx_start while busy is ignored
    send_frame(8'h1C, 11'h438, "busy_poke", 100, 1'b0);
    ok = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (tx_busy || debug != ST_IDLE) ok = 1'b0;
    end
    check("busy_poke_not_queued", 32'(ok), 32'd1);

    // async reset in the low phase of bit 3
    host_clear();
    @(negedge clk);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    guard = 0;
    while (!(frame_bits() == 4 && debug == ST_BIT_LOW) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("rst_mid_reach", 32'(guard < 1000), 32'd1);
    @(negedge clk);
    check("rst_mid_driving", 32'({ps2_clk, ps2_data}), 32'h0);
    reset = 1'b0;
    #1;
    check("rst_mid_lines", 32'({ps2_clk, ps2_data}), 32'h3);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_pulses", 32'({tx_done, tx_aborted}), 32'h0);
    check("rst_mid_debug", 32'(debug), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    host_clear();
    send_frame(8'h1C, 11'h438, "after_rst", -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
